// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider definitions: state encodings and constants
package div_unit_pkg;

    localparam int DIV_DATA_W = 32;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_DIVZERO = 2'd1,
        DIV_BUSY    = 2'd2,
        DIV_DONE    = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational radix-2 restoring division iteration
module div_unit_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_in,
    input  logic              bit_in,
    input  logic [DATA_W-1:0] dvsr,
    output logic [DATA_W:0]   rem_out,
    output logic              q_bit
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] trial;

    // Shift the next dividend bit in, subtract the divisor, restore when negative.
    always_comb begin
        shifted = {rem_in[DATA_W-1:0], bit_in};
        trial   = {1'b0, shifted} - {2'b00, dvsr};
        if (trial[DATA_W+1] == 1'b0) begin
            rem_out = trial[DATA_W:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted;
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle DIV/DIVU unit: FSM, iteration counter and sign fix-up
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start_div,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   opdata1,
    input  logic [DATA_W-1:0]   opdata2,
    input  logic                annul,
    output logic [2*DATA_W-1:0] result,
    output logic                ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    div_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   prem;
    logic [DATA_W-1:0] q_reg;     // dividend bits shift out as quotient bits shift in
    logic [DATA_W-1:0] dvsr;
    logic              qneg, rneg;

    logic [DATA_W:0]   step_rem;
    logic              step_q;
    logic [DATA_W-1:0] mag1, mag2;
    logic [DATA_W-1:0] quot_final, rem_final;

    div_unit_step #(.DATA_W(DATA_W)) u_step (
        .rem_in  (prem),
        .bit_in  (q_reg[DATA_W-1]),
        .dvsr    (dvsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Operand magnitudes at start and signed fix-up of the final iteration's output.
    always_comb begin
        mag1 = (signed_div && opdata1[DATA_W-1]) ? (~opdata1 + 1'b1) : opdata1;
        mag2 = (signed_div && opdata2[DATA_W-1]) ? (~opdata2 + 1'b1) : opdata2;
        quot_final = {q_reg[DATA_W-2:0], step_q};
        rem_final  = step_rem[DATA_W-1:0];
        if (qneg) begin
            quot_final = ~quot_final + 1'b1;
        end
        if (rneg) begin
            rem_final = ~rem_final + 1'b1;
        end
    end

    // Next-state logic; annul wins over everything, start_div low aborts or retires.
    always_comb begin
        state_next = state;
        if (annul) begin
            state_next = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start_div) begin
                        state_next = (opdata2 == '0) ? DIV_DIVZERO : DIV_BUSY;
                    end
                end
                DIV_DIVZERO: state_next = start_div ? DIV_DONE : DIV_IDLE;
                DIV_BUSY: begin
                    if (!start_div) begin
                        state_next = DIV_IDLE;
                    end else if (cnt == LAST_CNT) begin
                        state_next = DIV_DONE;
                    end
                end
                DIV_DONE: state_next = start_div ? DIV_DONE : DIV_IDLE;
                default:  state_next = DIV_IDLE;
            endcase
        end
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            prem   <= '0;
            q_reg  <= '0;
            dvsr   <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            state <= state_next;
            // ready rises once the result has sat in DONE for a full cycle
            ready <= (state == DIV_DONE) && (state_next == DIV_DONE);
            if (state_next == DIV_IDLE) begin
                result <= '0;
            end
            case (state)
                DIV_IDLE: begin
                    if (state_next != DIV_IDLE) begin
                        // divide-by-zero keeps the raw dividend for the HI half
                        q_reg <= (state_next == DIV_DIVZERO) ? opdata1 : mag1;
                        dvsr  <= mag2;
                        qneg  <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
                        rneg  <= signed_div & opdata1[DATA_W-1];
                        prem  <= '0;
                        cnt   <= '0;
                    end
                end
                DIV_DIVZERO: begin
                    if (state_next == DIV_DONE) begin
                        result <= {q_reg, DATA_W'(DIV_ZERO_QUOT)};
                    end
                end
                DIV_BUSY: begin
                    prem  <= step_rem;
                    q_reg <= {q_reg[DATA_W-2:0], step_q};
                    cnt   <= cnt + 1'b1;
                    if (state_next == DIV_DONE) begin
                        result <= {rem_final, quot_final};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking scoreboard bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_div = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int compared = 0;
    int mismatched = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_div  (start_div),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    // Drive a request, hold start until ready, then release it like the ALU does.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] expv, output int edges,
                         output logic [63:0] res, output logic timed_out);
        @(negedge clk);
        start_div = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        // scramble operands after the sample; they must be ignored
        opdata1 = ~a; opdata2 = b ^ 32'h5A5A_0001; signed_div = ~sgn;
        edges = 0;
        timed_out = 1'b0;
        res = '0;
        while (1) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready) begin
                res = result;
                break;
            end
            if (edges > 100) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start_div = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            mismatched++;
            $display("FAIL reset: ready=%b result=%h required ready=0 result=0", ready, result);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic [63:0] expv, input int exp_edges);
        int edges;
        logic [63:0] res, want;
        logic to;
        do_op(a, b, sgn, expv, edges, res, to);
        want = exp_q.pop_front();
        compared++;
        if (to || res !== want) begin
            mismatched++;
            $display("FAIL %s result: got %h timeout=%b required %h", name, res, to, want);
        end
        compared++;
        if (edges !== exp_edges) begin
            mismatched++;
            $display("FAIL %s latency: got %0d edges required %0d", name, edges, exp_edges);
        end
        @(posedge clk);
        #1;
        compared++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            mismatched++;
            $display("FAIL %s release: ready=%b result=%h required 0/0", name, ready, result);
        end
    endtask

    task automatic test_divu_basic();
        check_op("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    endtask

    task automatic test_signed();
        check_op("div_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        check_op("div_7_m2", 32'h7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33);
        check_op("divu_big", 32'hFFFF_FFF9, 32'h2, 1'b0, {32'h1, 32'h7FFF_FFFC}, 33);
    endtask

    task automatic test_boundary();
        check_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
        check_op("divu_max_1", 32'hFFFF_FFFF, 32'h1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 33);
        check_op("divu_small_big", 32'd5, 32'hFFFF_FFFF, 1'b0, {32'd5, 32'd0}, 33);
    endtask

    task automatic test_divzero();
        check_op("divzero", 32'h1234, 32'h0, 1'b0, {32'h1234, 32'hFFFF_FFFF}, 2);
        check_op("divzero_s", 32'h8000_0001, 32'h0, 1'b1, {32'h8000_0001, 32'hFFFF_FFFF}, 2);
    endtask

    // Abort mid-operation (annul or reset) and make sure no result ever appears.
    task automatic abort_op(input string name, input logic use_reset);
        int seen;
        @(negedge clk);
        start_div = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        @(posedge clk);
        repeat (use_reset ? 20 : 10) @(posedge clk);
        @(negedge clk);
        if (use_reset) resetn = 1'b0;
        else annul = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            mismatched++;
            $display("FAIL %s abort: ready=%b result=%h required 0/0", name, ready, result);
        end
        @(negedge clk);
        resetn = 1'b1; annul = 1'b0; start_div = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL %s stray_ready: got %0d ready cycles required 0", name, seen);
        end
    endtask

    task automatic test_annul();
        abort_op("annul", 1'b0);
        check_op("after_annul_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);
    endtask

    task automatic test_reset_midop();
        abort_op("reset_mid", 1'b1);
        check_op("after_reset_50_5", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33);
    endtask

    // Random back-to-back requests against the language's truncating / and %.
    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic sgn;
        logic [63:0] expv;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i < 4) ? ($urandom & 32'h0000_FFFF) | 32'h1 : $urandom | 32'h1;
            sgn = i[0];
            if (sgn) begin
                if (a == 32'h8000_0000) a = 32'h8000_0001;
                expv = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end else begin
                expv = {a % b, a / b};
            end
            check_op("b2b", a, b, sgn, expv, 33);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_boundary();
        test_divzero();
        test_annul();
        test_reset_midop();
        test_back_to_back();
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
